key_lock: RTL and testbench

KEY_LOCK -- requirements
Module: key_lock

---
 rtl/key_lock_pkg.sv | 27 ++
 rtl/key_capture.sv | 33 +++
 rtl/key_lock.sv | 151 +++++++++++++++
 tb/tb_key_lock.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_lock_pkg.sv
// Shared types and constants for the keypad lock.
// Holds the FSM state encoding, special key codes and timer width.
// Imported by key_lock and key_capture.
package key_lock_pkg;

  // Width of the OPEN/LOCKOUT down-counter.
  localparam int TIMER_W = 24;

  // Special keypad codes; 0-9 are digits, A/B/E/F are ignored.
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hD;

  // Length of the digit buffer.
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  // True for the ten decimal digit keys.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/key_capture.sv
// Keypad front end: turns the Valid level into a single-cycle key strobe.
// Latency: strobe is combinational from Valid and the registered Valid history.
// Backpressure: none; a held key yields one strobe, later edges while held are ignored.
module key_capture
  import key_lock_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Valid,
  input  logic [3:0] Code,
  output logic       key_stb_o,
  output logic [3:0] key_o
);

  // Valid history; forced high in reset so a key held through reset
  // release does not look like a fresh press.
  logic valid_q;

  // Track the previous-cycle Valid level for rising-edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b1;
    end else begin
      valid_q <= Valid;
    end
  end

  // The key code is consumed by the lock FSM on the very edge that
  // samples the strobe, so the code is registered there.
  assign key_stb_o = Valid & ~valid_q;
  assign key_o     = Code;

endmodule

// File: rtl/key_lock.sv
// Four-digit BCD keypad lock with timed OPEN window and failed-attempt lockout.
// Latency: an accepted key affects Entry/Count/Unlock/Locked/Error one Clk later.
// Backpressure: none; keys arriving outside ENTRY are dropped, not queued.
module key_lock
  import key_lock_pkg::*;
#(
  parameter logic [15:0]        PASSCODE       = 16'h1234,
  parameter logic [TIMER_W-1:0] UNLOCK_CYCLES  = 24'd5_000_000,
  parameter logic [TIMER_W-1:0] LOCKOUT_CYCLES = 24'd10_000_000,
  parameter int unsigned        MAX_FAIL       = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Code,
  input  logic        Valid,
  output logic        Unlock,
  output logic        Locked,
  output logic        Error,
  output logic [15:0] Entry,
  output logic [2:0]  Count
);

  // Fail counter only needs to reach MAX_FAIL before it is cleared.
  localparam int FAIL_W = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

  logic               key_stb;
  logic [3:0]         key;

  state_e             state_q,  state_d;
  logic [15:0]        entry_q,  entry_d;
  logic [2:0]         count_q,  count_d;
  logic [FAIL_W-1:0]  fail_q,   fail_d;
  logic [FAIL_W-1:0]  fail_inc;
  logic [TIMER_W-1:0] timer_q,  timer_d;
  logic               error_q,  error_d;
  logic               unlock_q, unlock_d;
  logic               locked_q, locked_d;

  key_capture u_capture (
    .Clk       (Clk),
    .Reset     (Reset),
    .Valid     (Valid),
    .Code      (Code),
    .key_stb_o (key_stb),
    .key_o     (key)
  );

  assign fail_inc = fail_q + 1'b1;

  // Next-state logic: key handling in ENTRY, countdown in OPEN/LOCKOUT.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    error_d = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (key_stb) begin
          if (is_digit(key)) begin
            // Shift in the newest digit; beyond four the oldest falls off.
            entry_d = {entry_q[11:0], key};
            if (count_q < MAX_DIGITS) begin
              count_d = count_q + 3'd1;
            end
          end else if (key == KEY_CLEAR) begin
            entry_d = '0;
            count_d = '0;
          end else if (key == KEY_ENTER) begin
            if ((count_q == MAX_DIGITS) && (entry_q == PASSCODE)) begin
              // Digits stay visible while open; cleared on expiry.
              state_d = ST_OPEN;
              timer_d = UNLOCK_CYCLES;
              fail_d  = '0;
            end else begin
              error_d = 1'b1;
              entry_d = '0;
              count_d = '0;
              if (fail_inc >= FAIL_LIMIT) begin
                state_d = ST_LOCKOUT;
                timer_d = LOCKOUT_CYCLES;
                fail_d  = '0;
              end else begin
                fail_d  = fail_inc;
              end
            end
          end
          // A, B, E, F fall through untouched.
        end
      end

      ST_OPEN, ST_LOCKOUT: begin
        // The state lasts exactly the loaded number of cycles: the cycle
        // holding timer==1 is the last one, and the timer lands on 0 as
        // ENTRY resumes. Keys in this window, including the last cycle,
        // are dropped.
        if (timer_q <= TIMER_W'(1)) begin
          state_d = ST_ENTRY;
          timer_d = '0;
          entry_d = '0;
          count_d = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      default: begin
        state_d = ST_ENTRY;
        entry_d = '0;
        count_d = '0;
        timer_d = '0;
      end
    endcase

    unlock_d = (state_d == ST_OPEN);
    locked_d = (state_d == ST_LOCKOUT);
  end

  // State and output registers; reset aborts OPEN/LOCKOUT on any cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_ENTRY;
      entry_q  <= '0;
      count_q  <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      error_q  <= 1'b0;
      unlock_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      error_q  <= error_d;
      unlock_q <= unlock_d;
      locked_q <= locked_d;
    end
  end

  assign Unlock = unlock_q;
  assign Locked = locked_q;
  assign Error  = error_q;
  assign Entry  = entry_q;
  assign Count  = count_q;

endmodule

// File: tb/tb_key_lock.sv
// Scoreboard bench for key_lock: a key-level model predicts each output change.
// Monitor compares every change of the output snapshot against the queue head.
// Timed states also have their duration checked against the expected cycle count.
module tb_key_lock;

  localparam logic [15:0] PASS = 16'h1234;
  localparam int UC = 8;
  localparam int LC = 16;
  localparam int MF = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Valid;
  logic [3:0]  Code;
  logic        Unlock, Locked, Error;
  logic [15:0] Entry;
  logic [2:0]  Count;

  always #5 Clk = ~Clk;

  key_lock #(
    .PASSCODE       (PASS),
    .UNLOCK_CYCLES  (24'(UC)),
    .LOCKOUT_CYCLES (24'(LC)),
    .MAX_FAIL       (MF)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Code   (Code),
    .Valid  (Valid),
    .Unlock (Unlock),
    .Locked (Locked),
    .Error  (Error),
    .Entry  (Entry),
    .Count  (Count)
  );

  typedef struct packed {
    logic [15:0] entry;
    logic [2:0]  count;
    logic        unlock;
    logic        locked;
    logic        error;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dur;   // cycles until the following change; 0 = not checked
  } exp_t;

  exp_t  expq[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- reference model (key level) ----------------
  int    m_entry;
  int    m_count;
  int    m_fail;
  int    busy_until;
  snap_t last_snap;

  function automatic snap_t mk(input int e, input int c, input bit u, input bit l, input bit er);
    snap_t s;
    s.entry  = 16'(e);
    s.count  = 3'(c);
    s.unlock = u;
    s.locked = l;
    s.error  = er;
    return s;
  endfunction

  task automatic push(input snap_t s, input int dur);
    exp_t e;
    if (s != last_snap) begin
      e.s = s;
      e.dur = dur;
      expq.push_back(e);
      last_snap = s;
    end
  endtask

  // Key whose Valid rise is first sampled on posedge number p.
  task automatic model_key(input logic [3:0] c, input int p);
    if (p <= busy_until) return;          // OPEN or LOCKOUT (incl. expiry cycle)
    if (c <= 4'd9) begin
      m_entry = ((m_entry * 16) + int'(c)) % 65536;
      if (m_count < 4) m_count++;
      push(mk(m_entry, m_count, 0, 0, 0), 0);
    end else if (c == 4'hC) begin
      m_entry = 0;
      m_count = 0;
      push(mk(0, 0, 0, 0, 0), 0);
    end else if (c == 4'hD) begin
      if (m_count == 4 && m_entry == int'(PASS)) begin
        push(mk(m_entry, 4, 1, 0, 0), UC);
        push(mk(0, 0, 0, 0, 0), 0);
        busy_until = p + UC;
        m_fail = 0;
      end else begin
        m_fail++;
        if (m_fail == MF) begin
          push(mk(0, 0, 0, 1, 1), 1);
          push(mk(0, 0, 0, 1, 0), LC - 1);
          push(mk(0, 0, 0, 0, 0), 0);
          busy_until = p + LC;
          m_fail = 0;
        end else begin
          push(mk(0, 0, 0, 0, 1), 1);
          push(mk(0, 0, 0, 0, 0), 0);
        end
      end
      m_entry = 0;
      m_count = 0;
    end
  endtask

  task automatic model_reset();
    m_entry = 0;
    m_count = 0;
    m_fail = 0;
    busy_until = 0;
    push(mk(0, 0, 0, 0, 0), 0);
  endtask

  // ---------------- monitor ----------------
  snap_t prev;
  int    prev_cyc;
  int    prev_dur;
  bit    mon_en   = 1'b0;
  bit    dur_skip = 1'b0;

  // Compare each change of the output snapshot with the next expectation.
  always @(negedge Clk) begin
    snap_t cur;
    exp_t  e;
    if (mon_en) begin
      cur = {Entry, Count, Unlock, Locked, Error};
      if (cur != prev) begin
        checks++;
        if (cur.unlock && (cur.locked || cur.error)) begin
          failures++;
          $display("FAIL exclusive cyc=%0d unlock=%b locked=%b error=%b", cyc, cur.unlock, cur.locked, cur.error);
        end
        if (prev_dur != 0 && !dur_skip) begin
          checks++;
          if (cyc - prev_cyc != prev_dur) begin
            failures++;
            $display("FAIL duration cyc=%0d got=%0d exp=%0d", cyc, cyc - prev_cyc, prev_dur);
          end
        end
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
          prev_dur = 0;
        end else begin
          e = expq.pop_front();
          if (e.s !== cur) begin
            failures++;
            $display("FAIL snapshot cyc=%0d got entry=%h count=%0d u=%b l=%b e=%b exp entry=%h count=%0d u=%b l=%b e=%b",
                     cyc, cur.entry, cur.count, cur.unlock, cur.locked, cur.error,
                     e.s.entry, e.s.count, e.s.unlock, e.s.locked, e.s.error);
          end
          prev_dur = e.dur;
        end
        prev     = cur;
        prev_cyc = cyc;
        dur_skip = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic press(input logic [3:0] c, input int hold, input int gap);
    @(negedge Clk);
    Code  = c;
    Valid = 1'b1;
    model_key(c, cyc + 1);
    repeat (hold) @(negedge Clk);
    Valid = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic press_seq(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                           input logic [3:0] k3, input logic [3:0] k4, input int hold, input int gap);
    press(k0, hold, gap);
    press(k1, hold, gap);
    press(k2, hold, gap);
    press(k3, hold, gap);
    press(k4, hold, gap);
  endtask

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset(input bit hold_valid);
    @(negedge Clk);
    Reset    = 1'b1;
    dur_skip = 1'b1;
    model_reset();
    if (hold_valid) begin
      Code  = 4'd7;
      Valid = 1'b1;
    end
    @(negedge Clk);
    check_eq("reset_unlock", int'(Unlock), 0);
    check_eq("reset_outputs", int'({Locked, Error, Count, Entry}), 0);
    @(negedge Clk);
    Reset    = 1'b0;
    dur_skip = 1'b0;
    if (hold_valid) begin
      repeat (4) @(negedge Clk);
      Valid = 1'b0;
    end
  endtask

  initial begin
    Reset = 1'b1;
    Valid = 1'b0;
    Code  = 4'h0;
    m_entry = 0;
    m_count = 0;
    m_fail = 0;
    busy_until = 0;
    last_snap = '0;
    prev = '0;
    prev_cyc = 0;
    prev_dur = 0;
    repeat (3) @(negedge Clk);
    check_eq("init_unlock", int'(Unlock), 0);
    check_eq("init_locked", int'(Locked), 0);
    check_eq("init_error", int'(Error), 0);
    check_eq("init_entry", int'(Entry), 0);
    check_eq("init_count", int'(Count), 0);
    prev   = {Entry, Count, Unlock, Locked, Error};
    mon_en = 1'b1;
    Reset  = 1'b0;

    // Correct code, long holds: open for exactly UC cycles, then cleared.
    press_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'hD, 5, 2);
    repeat (UC + 4) @(negedge Clk);
    check_eq("after_open_count", int'(Count), 0);

    // Five digits: leading 9 drops out.
    press(4'd9, 2, 1);
    press_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'hD, 2, 1);
    repeat (UC + 4) @(negedge Clk);

    // Three wrong attempts -> lockout; correct code during lockout ignored.
    press_seq(4'd1, 4'd2, 4'd3, 4'd5, 4'hD, 1, 1);
    press_seq(4'd1, 4'd2, 4'd3, 4'd5, 4'hD, 1, 1);
    press_seq(4'd1, 4'd2, 4'd3, 4'd5, 4'hD, 1, 0);
    press_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'hD, 1, 0);
    repeat (LC + 4) @(negedge Clk);

    // Short entry fails; clear keeps the fail count, so two more fails lock.
    press(4'd1, 1, 1);
    press(4'd2, 1, 1);
    press(4'hD, 1, 1);
    press(4'd1, 1, 1);
    press(4'hC, 1, 1);
    press(4'hA, 1, 1);
    press(4'hD, 1, 1);
    press(4'hD, 1, 1);
    repeat (LC + 4) @(negedge Clk);

    // Long hold counts once; reset mid-OPEN drops Unlock at once.
    press(4'd7, 20, 1);
    press(4'hC, 1, 1);
    press_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'hD, 1, 1);
    repeat (2) @(negedge Clk);
    do_reset(1'b0);
    // Valid held through reset release must not register.
    do_reset(1'b1);
    repeat (3) @(negedge Clk);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        press_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'hD, $urandom_range(1, 4), $urandom_range(0, 3));
      end else begin
        press(4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(0, 3));
      end
    end

    repeat (UC + LC + 10) @(negedge Clk);
    check_eq("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
